instruction_fetch_mem: RTL and testbench
========================================

// Module: instruction_fetch_mem
// PURPOSE
//  Parametrised, clocked instruction memory for the fetch stage.
//  Byte-addressed, word-aligned reads use a valid/ready request channel and a pipelined response channel.
//  The read latency is configurable, and the response channel supports back-pressure.
//  Alignment and range errors are flagged on the response.
//  A write port preloads programs from the testbench or loader.
//  Successor to the combinational word ROM: adds latency, flow control and error reporting.
// PARAMETERS
//  DATA_WIDTH  32   instruction word width (bits)
//  ADDR_WIDTH  32   byte-address width
//  DEPTH       128  number of words; power of two, >= 2
//  LATENCY     2    read pipeline stages, legal 1..4
//  INIT_MULT   3    time-zero init: mem[i] = i*INIT_MULT mod 2^DATA_WIDTH
// PORTS
//  Clk          in   1           rising-edge clock
//  Reset        in   1           synchronous, active-high reset
//  ReqValid     in   1           fetch request present
//  ReqReady     out  1           request accepted this edge if ReqValid
//  Address      in   ADDR_WIDTH  byte address of requested word
//  RespValid    out  1           Instruction/RespError valid
//  RespReady    in   1           consumer takes response this edge
//  Instruction  out  DATA_WIDTH  fetched word (0 on error)
//  RespError    out  1           misaligned or out-of-range request
//  WrEn         in   1           write strobe
//  WrAddress    in   ADDR_WIDTH  byte address to write
//  WrData       in   DATA_WIDTH  word to write
// BEHAVIOUR
//  - IDXW = clog2(DEPTH); word index = Address[IDXW+1:2].
//  - Error = Address[1:0]!=0, or Address[ADDR_WIDTH-1:IDXW+2]!=0.
//  - Memory contents are set only at time zero (INIT_MULT) or via WrEn; Reset never clears them.
//  - Reset: all stage valid bits clear; RespValid=0, Instruction=0, RespError=0.
//  - Reset drops in-flight requests; they are never replayed.
//  - Reset wins over any simultaneous accept or write-read.
//  - The write itself is still performed if WrEn is asserted during Reset.
//  - Pipeline: LATENCY stage registers (valid, data, err); stage LATENCY drives the outputs.
//  - advance = !RespValid | RespReady; ReqReady = advance (combinational from RespReady).
//  - Accept = ReqValid & ReqReady. Memory is read in the accept cycle and the result is captured in stage 1.
//  - All stages shift together on advance; bubbles propagate as valid=0.
//  - Latency: a request accepted at edge k appears at the outputs after edge k+LATENCY-1.
//  - With no stall, back-to-back accepts give one response per cycle, in order.
//  - While RespValid & !RespReady: outputs held stable, no stage shifts, ReqReady=0.
//  - Write: on edge with WrEn & WrAddress aligned & in range, mem[idx] <= WrData.
//  - Writes that are misaligned or out of range are ignored silently.
//  - Same-edge write and accept to the same index: the read returns the OLD word (read-before-write).
//  - The new word is visible to accepts on later edges.
//  - Error response: RespError=1, Instruction=0, same latency/ordering as normal reads.
//  - No internal counters wrap; index truncation is excluded by the range check.
// TESTING
//  1. Default params, Reset 2 cycles, ReqValid=1 Address=0x10 for one accepted cycle -> RespValid after 2nd edge, Instruction=0x0000000C, RespError=0.
//  2. Back-to-back addresses 0x0,0x4,0x8,0xC, RespReady=1 -> responses 0,3,6,9 on consecutive cycles, ReqReady constantly 1.
//  3. RespReady=0 for 3 cycles while 2 in flight -> outputs frozen, ReqReady=0; on release the order is preserved with no loss or duplication.
//  4. Address=0x6 -> RespError=1, Instruction=0; Address=0x200 (DEPTH=128) -> RespError=1; the next request, 0x1FC, -> 0x17D (381), no error.
//  5. WrEn WrAddress=0x8 WrData=0xDEADBEEF plus a same-edge read of 0x8 -> 6. A read of 0x8 accepted on the next edge -> 0xDEADBEEF.
//  6. Reset asserted with 2 requests in flight -> RespValid=0 the next cycle; the dropped responses never appear; LATENCY=1 and 4 runs repeat test 2 with latency 1/4.

Source files
------------

// File: rtl/instruction_fetch_mem_if.sv
// Fetch-memory bus: valid/ready read request, back-pressured response, preload write port.
interface instruction_fetch_mem_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] address;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  resp_error;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_address;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output req_valid, address, resp_ready, wr_en, wr_address, wr_data,
        input  req_ready, resp_valid, instruction, resp_error
    );

    modport slave (
        input  req_valid, address, resp_ready, wr_en, wr_address, wr_data,
        output req_ready, resp_valid, instruction, resp_error
    );
endinterface

// File: rtl/instruction_fetch_mem.sv
// Word-aligned instruction memory with a LATENCY-deep read pipeline, response
// back-pressure, alignment/range error reporting and a preload write port.
module instruction_fetch_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned INIT_MULT  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    instruction_fetch_mem_if.slave  bus
);
    localparam int unsigned IDXW = $clog2(DEPTH);

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef word_t mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = DATA_WIDTH'(64'(i) * 64'(INIT_MULT));
        end
        return m;
    endfunction

    // Power-up image; only the write port changes it afterwards, never reset.
    mem_t mem = init_mem();

    logic [IDXW-1:0]    rd_idx;
    logic [IDXW-1:0]    wr_idx;
    logic               rd_err;
    logic               wr_ok;
    logic               advance;
    logic               accept;

    logic [LATENCY-1:0] stg_valid;
    logic [LATENCY-1:0] stg_err;
    word_t              stg_data [LATENCY];

    // Address decode for both ports; upper bits above the index must be zero.
    always_comb begin
        rd_idx = bus.address[IDXW+1:2];
        wr_idx = bus.wr_address[IDXW+1:2];
        rd_err = (bus.address[1:0] != 2'b00) || ((bus.address >> (IDXW + 2)) != '0);
        wr_ok  = bus.wr_en && (bus.wr_address[1:0] == 2'b00)
                 && ((bus.wr_address >> (IDXW + 2)) == '0);
    end

    // The whole pipeline moves as one; a held output stalls every stage.
    assign advance       = !stg_valid[LATENCY-1] || bus.resp_ready;
    assign accept        = bus.req_valid && advance;
    assign bus.req_ready = advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
            stg_err   <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stg_data[i] <= '0;
            end
        end else if (advance) begin
            stg_valid[0] <= accept;
            stg_err[0]   <= accept && rd_err;
            stg_data[0]  <= (accept && !rd_err) ? mem[rd_idx] : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_err[i]   <= stg_err[i-1];
                stg_data[i]  <= stg_data[i-1];
            end
        end
    end

    // Non-blocking write gives read-before-write for a same-edge accept.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= bus.wr_data;
        end
    end

    assign bus.resp_valid  = stg_valid[LATENCY-1];
    assign bus.resp_error  = stg_err[LATENCY-1];
    assign bus.instruction = stg_data[LATENCY-1];
endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Scoreboard bench: three instances (LATENCY 1, 2, 4) share stimulus; one
// monitor pops per-instance expectation queues on every response transfer.
module tb_instruction_fetch_mem;
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        bit          timed;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] address = '0;
    logic        resp_ready = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_address = '0;
    logic [31:0] wr_data = '0;

    logic [2:0]  rv;
    logic [2:0]  rq;
    logic [2:0]  re;
    logic [31:0] ri [3];

    exp_t sb [3][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        instruction_fetch_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
        assign bus.req_valid  = req_valid;
        assign bus.address    = address;
        assign bus.resp_ready = resp_ready;
        assign bus.wr_en      = wr_en;
        assign bus.wr_address = wr_address;
        assign bus.wr_data    = wr_data;
        assign rv[g] = bus.resp_valid;
        assign rq[g] = bus.req_ready;
        assign re[g] = bus.resp_error;
        assign ri[g] = bus.instruction;

        instruction_fetch_mem #(
            .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(128),
            .LATENCY((g == 0) ? 1 : (g == 1) ? 2 : 4), .INIT_MULT(3)
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus.slave)
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lat=%0d got=%h want=%h", name, lat_of(inst), got, exp);
        end
    endtask

    // Drive one request (optionally with a same-cycle write) and record expectations.
    task automatic issue_w(input logic [31:0] a, input logic [31:0] d, input logic e, input bit timed,
                           input logic we, input logic [31:0] wa, input logic [31:0] wd);
        exp_t x;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        address    = a;
        wr_en      = we;
        wr_address = wa;
        wr_data    = wd;
        #1;
        x.data = d; x.err = e; x.acc = cyc + 1; x.timed = timed;
        for (int i = 0; i < 3; i++) begin
            chk("req_ready", i, 32'(rq[i]), 32'd1);
            if (rq[i]) sb[i].push_back(x);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic e, input bit timed);
        issue_w(a, d, e, timed, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic write_only(input logic [31:0] wa, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b0; wr_en = 1'b1; wr_address = wa; wr_data = wd;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_valid = 1'b0; wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) chk("drain_pending", i, 32'(sb[i].size()), 32'd0);
    endtask

    // Monitor: a transfer happens on the next edge whenever valid & ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rv[i] && resp_ready) begin
                    checks++;
                    if (sb[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp lat=%0d got=%h err=%b", lat_of(i), ri[i], re[i]);
                    end else begin
                        e = sb[i].pop_front();
                        if (ri[i] !== e.data || re[i] !== e.err) begin
                            errors++;
                            $display("FAIL resp lat=%0d got=%h/%b want=%h/%b",
                                     lat_of(i), ri[i], re[i], e.data, e.err);
                        end
                        if (e.timed) begin
                            checks++;
                            if (cyc != e.acc + lat_of(i) - 1) begin
                                errors++;
                                $display("FAIL latency lat=%0d got_edge=%0d want_edge=%0d",
                                         lat_of(i), cyc, e.acc + lat_of(i) - 1);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", i, 32'(rv[i]), 32'd0);
            chk("rst_instr", i, ri[i], 32'd0);
            chk("rst_err", i, 32'(re[i]), 32'd0);
        end
        reset = 1'b0;

        // Single read, then back-to-back reads
        issue(32'h10, 32'h0000000C, 1'b0, 1'b1);
        idle(); drain();
        issue(32'h0, 32'd0, 1'b0, 1'b1);
        issue(32'h4, 32'd3, 1'b0, 1'b1);
        issue(32'h8, 32'd6, 1'b0, 1'b1);
        issue(32'hC, 32'd9, 1'b0, 1'b1);
        idle(); drain();

        // Back-pressure: two in flight, consumer stalls three cycles
        issue(32'h20, 32'h18, 1'b0, 1'b0);
        issue(32'h24, 32'h1B, 1'b0, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0; resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            chk("stall_valid", 1, 32'(rv[1]), 32'd1);
            chk("stall_instr", 1, ri[1], 32'h18);
            chk("stall_ready", 1, 32'(rq[1]), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        drain();

        // Errors, then top word of memory
        issue(32'h6, 32'd0, 1'b1, 1'b1);
        issue(32'h200, 32'd0, 1'b1, 1'b1);
        issue(32'h1FC, 32'h17D, 1'b0, 1'b1);
        idle(); drain();

        // Write with same-edge read, then rejected writes that would alias word 2
        issue_w(32'h8, 32'd6, 1'b0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
        issue(32'h8, 32'hDEADBEEF, 1'b0, 1'b1);
        write_only(32'h9, 32'h11111111);
        write_only(32'h208, 32'h22222222);
        issue(32'h8, 32'hDEADBEEF, 1'b0, 1'b1);
        idle(); drain();

        // Reset with requests in flight; unconsumed ones must vanish
        issue(32'h30, 32'h24, 1'b0, 1'b1);
        issue(32'h34, 32'h27, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            sb[i].delete();
            chk("reset_flush_valid", i, 32'(rv[i]), 32'd0);
        end
        reset = 1'b0;
        repeat (6) @(posedge clk);
        issue(32'h4, 32'd3, 1'b0, 1'b1);
        idle(); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
